// File: rtl/gate_response_checker.sv
// Response checker for the a/b/d two-output gate block.
// Queues expected outputs per vector, compares returning responses in order.
module gate_response_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   stim_valid,
  input  logic                   stim_a,
  input  logic                   stim_b,
  input  logic                   stim_d,
  input  logic                   obs_valid,
  input  logic                   obs_out1,
  input  logic                   obs_out2,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   mismatch,
  output logic [2:0]             first_bad_vec,
  output logic [1:0]             first_bad_obs,
  output logic [1:0]             state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FAIL = 2'd2
  } state_e;

  // entry = {exp_out1, exp_out2, a, b, d}
  logic [4:0]       mem_q [DEPTH];
  logic [4:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             mis_q, mis_d;
  logic [2:0]       bad_vec_q, bad_vec_d;
  logic [1:0]       bad_obs_q, bad_obs_d;
  state_e           state_q, state_d;

  logic       full, empty;
  logic       push_ok, pop_ok;
  logic       ovf_ev, udf_ev, mis_ev;
  logic [4:0] head;
  logic [4:0] new_ent;
  logic       ab;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign pop_ok  = obs_valid & ~empty;
  // a pop on a full queue frees the slot for a same-cycle push
  assign push_ok = stim_valid & (~full | obs_valid);
  assign ovf_ev  = stim_valid & full & ~obs_valid;
  assign udf_ev  = obs_valid & empty;
  assign head    = mem_q[rd_ptr_q];
  assign mis_ev  = pop_ok & ({obs_out1, obs_out2} != head[4:3]);
  assign ab      = stim_a & stim_b;
  assign new_ent = {ab, ab & stim_d, stim_a, stim_b, stim_d};

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    mis_d     = mis_q;
    bad_vec_d = bad_vec_q;
    bad_obs_d = bad_obs_q;
    state_d   = state_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      pass_d    = '0;
      fail_d    = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      mis_d     = 1'b0;
      bad_vec_d = '0;
      bad_obs_d = '0;
      state_d   = S_IDLE;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = new_ent;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + PW'(push_ok) - PW'(pop_ok);
      if (pop_ok && !mis_ev && !(&pass_q)) begin
        pass_d = pass_q + 1'b1;
      end
      if (mis_ev) begin
        if (!(&fail_q)) begin
          fail_d = fail_q + 1'b1;
        end
        mis_d = 1'b1;
        if (!mis_q) begin
          bad_vec_d = head[2:0];
          bad_obs_d = {obs_out1, obs_out2};
        end
      end
      if (ovf_ev) ovf_d = 1'b1;
      if (udf_ev) udf_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (udf_ev)       state_d = S_FAIL;
          else if (push_ok) state_d = S_RUN;
        end
        S_RUN: begin
          if (mis_ev || ovf_ev || udf_ev) state_d = S_FAIL;
          else if (cnt_d == '0)           state_d = S_IDLE;
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      mis_q     <= 1'b0;
      bad_vec_q <= '0;
      bad_obs_q <= '0;
      state_q   <= S_IDLE;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      mis_q     <= mis_d;
      bad_vec_q <= bad_vec_d;
      bad_obs_q <= bad_obs_d;
      state_q   <= state_d;
    end
  end

  assign pass_cnt      = pass_q;
  assign fail_cnt      = fail_q;
  assign pending       = cnt_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign mismatch      = mis_q;
  assign first_bad_vec = bad_vec_q;
  assign first_bad_obs = bad_obs_q;
  assign state         = state_q;

endmodule
